// File: rtl/hyperram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hyperram_arb_pkg
//  Description : Shared definitions for the two-requester HyperRAM command
//                arbiter: arbiter state encoding and default bus widths.
//  Contents    : HR_ADDR_W  - default HyperRAM word address width
//                HR_DATA_W  - default data word width
//                arb_state_e - IDLE / ISSUE / WAIT
//  Revision    : 1.0 - initial release
// ============================================================================
package hyperram_arb_pkg;

   localparam int unsigned HR_ADDR_W = 22;
   localparam int unsigned HR_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

endpackage : hyperram_arb_pkg
`default_nettype wire

// File: rtl/hyperram_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : hyperram_rr_pick
//  Description : Two-way round-robin pick. When both requesters are valid the
//                one that was not granted last wins; a lone valid requester
//                always wins; no valid requester gives no grant.
//  Ports       : valid[1:0] in  - per-requester valid
//                lastGrant  in  - index of the requester granted last
//                grant[1:0] out - one-hot (or zero) grant
//  Revision    : 1.0 - initial release
// ============================================================================
module hyperram_rr_pick (
   input  logic [1:0] valid,
   input  logic       lastGrant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = lastGrant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule : hyperram_rr_pick
`default_nettype wire

// File: rtl/hyperram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hyperram_cmd_arbiter
//  Description : Arbitrates single-word commands from two requesters onto one
//                HyperRAM controller command port. One command is in flight
//                at a time: IDLE (offer reqReady) -> ISSUE (commandEnable
//                strobe) -> WAIT (read data or write completion) -> IDLE.
//  Parameters  : ADDR_W, DATA_W, TIMEOUT_CYCLES (watchdog limit)
//  Ports       : userClock, userResetN (async active-low)
//                reqValid/reqRead/reqAddress/reqWriteData in, reqReady out
//                rspValid[1:0], rspData out
//                commandEnable, cmdRead, cmdAddress, cmdWriteData out
//                ctrlBusy, readDataValid, readReg in
//                timeoutError out (sticky)
//  Options     : HYPERRAM_ARB_TIMEOUT_EN - adds a WAIT watchdog that forces
//                completion after TIMEOUT_CYCLES cycles and sets timeoutError.
//                Undefined: no watchdog, timeoutError tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module hyperram_cmd_arbiter
   import hyperram_arb_pkg::*;
#(
   parameter int ADDR_W         = HR_ADDR_W,
   parameter int DATA_W         = HR_DATA_W,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  userClock,
   input  logic                  userResetN,
   input  logic [1:0]            reqValid,
   input  logic [1:0]            reqRead,
   input  logic [2*ADDR_W-1:0]   reqAddress,
   input  logic [2*DATA_W-1:0]   reqWriteData,
   output logic [1:0]            reqReady,
   output logic [1:0]            rspValid,
   output logic [DATA_W-1:0]     rspData,
   output logic                  commandEnable,
   output logic                  cmdRead,
   output logic [ADDR_W-1:0]     cmdAddress,
   output logic [DATA_W-1:0]     cmdWriteData,
   input  logic                  ctrlBusy,
   input  logic                  readDataValid,
   input  logic [DATA_W-1:0]     readReg,
   output logic                  timeoutError
);

   // The watchdog compares against TIMEOUT_CYCLES-1, so it needs at least 2.
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("hyperram_cmd_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

   arb_state_e          state_q, state_d;
   logic [1:0]          reqReady_q, reqReady_d;
   logic [1:0]          rspValid_q, rspValid_d;
   logic [DATA_W-1:0]   rspData_q, rspData_d;
   logic                cmdEn_q, cmdEn_d;
   logic                cmdRead_q, cmdRead_d;
   logic [ADDR_W-1:0]   cmdAddr_q, cmdAddr_d;
   logic [DATA_W-1:0]   cmdData_q, cmdData_d;
   logic                lastGrant_q, lastGrant_d;
   logic                granted_q, granted_d;

   logic [1:0]          pickGrant;
   logic                accept;
   logic                accIdx;
   logic                done;

   hyperram_rr_pick u_pick (
      .valid     (reqValid),
      .lastGrant (lastGrant_q),
      .grant     (pickGrant)
   );

   // reqReady is registered and one-hot, so the accepted requester is simply
   // the set bit of reqReady_q. A requester that drops reqValid in the cycle
   // its ready is shown is not accepted and the pointer stays put.
   assign accept = (state_q == IDLE) && ((reqValid & reqReady_q) != 2'b00);
   assign accIdx = reqReady_q[1];

   // Completion condition in WAIT: reads finish on the read strobe, writes on
   // the first cycle the controller reports not-busy.
   assign done = cmdRead_q ? readDataValid : !ctrlBusy;

`ifdef HYPERRAM_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   logic [TW-1:0] wdCount_q;
   logic          wdHit;
   logic          timeoutError_q, timeoutError_d;

   assign wdHit = (state_q == WAIT) && (wdCount_q == TW'(TIMEOUT_CYCLES - 1));

   // Counts WAIT cycles; cleared everywhere else so each command starts at 0.
   always_ff @(posedge userClock or negedge userResetN) begin
      if (!userResetN) begin
         wdCount_q      <= '0;
         timeoutError_q <= 1'b0;
      end else begin
         timeoutError_q <= timeoutError_d;
         if (state_q == WAIT) begin
            wdCount_q <= wdCount_q + 1'b1;
         end else begin
            wdCount_q <= '0;
         end
      end
   end

   assign timeoutError = timeoutError_q;
`else
   assign timeoutError = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      reqReady_d  = 2'b00;
      rspValid_d  = 2'b00;
      rspData_d   = rspData_q;
      cmdEn_d     = 1'b0;
      cmdRead_d   = cmdRead_q;
      cmdAddr_d   = cmdAddr_q;
      cmdData_d   = cmdData_q;
      lastGrant_d = lastGrant_q;
      granted_d   = granted_q;
`ifdef HYPERRAM_ARB_TIMEOUT_EN
      timeoutError_d = timeoutError_q;
`endif

      case (state_q)
         IDLE: begin
            if (accept) begin
               cmdRead_d   = reqRead[accIdx];
               cmdAddr_d   = accIdx ? reqAddress[2*ADDR_W-1:ADDR_W]
                                    : reqAddress[ADDR_W-1:0];
               cmdData_d   = accIdx ? reqWriteData[2*DATA_W-1:DATA_W]
                                    : reqWriteData[DATA_W-1:0];
               lastGrant_d = accIdx;
               granted_d   = accIdx;
               cmdEn_d     = 1'b1;
               state_d     = ISSUE;
            end else if (!ctrlBusy) begin
               reqReady_d = pickGrant;
            end
         end

         ISSUE: begin
            state_d = WAIT;
         end

         WAIT: begin
            if (done) begin
               rspData_d  = cmdRead_q ? readReg : '0;
               rspValid_d = granted_q ? 2'b10 : 2'b01;
               state_d    = IDLE;
            end
`ifdef HYPERRAM_ARB_TIMEOUT_EN
            else if (wdHit) begin
               rspData_d      = '0;
               rspValid_d     = granted_q ? 2'b10 : 2'b01;
               timeoutError_d = 1'b1;
               state_d        = IDLE;
            end
`endif
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge userClock or negedge userResetN) begin
      if (!userResetN) begin
         state_q     <= IDLE;
         reqReady_q  <= 2'b00;
         rspValid_q  <= 2'b00;
         rspData_q   <= '0;
         cmdEn_q     <= 1'b0;
         cmdRead_q   <= 1'b0;
         cmdAddr_q   <= '0;
         cmdData_q   <= '0;
         lastGrant_q <= 1'b1;   // requester 0 wins the first tie
         granted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         reqReady_q  <= reqReady_d;
         rspValid_q  <= rspValid_d;
         rspData_q   <= rspData_d;
         cmdEn_q     <= cmdEn_d;
         cmdRead_q   <= cmdRead_d;
         cmdAddr_q   <= cmdAddr_d;
         cmdData_q   <= cmdData_d;
         lastGrant_q <= lastGrant_d;
         granted_q   <= granted_d;
      end
   end

   assign reqReady      = reqReady_q;
   assign rspValid      = rspValid_q;
   assign rspData       = rspData_q;
   assign commandEnable = cmdEn_q;
   assign cmdRead       = cmdRead_q;
   assign cmdAddress    = cmdAddr_q;
   assign cmdWriteData  = cmdData_q;

endmodule : hyperram_cmd_arbiter
`default_nettype wire

// File: tb/tb_hyperram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hyperram_cmd_arbiter
//  Description : Directed self-checking bench for hyperram_cmd_arbiter.
//                Define HYPERRAM_ARB_TIMEOUT_EN to also exercise the watchdog
//                (TIMEOUT_CYCLES = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hyperram_cmd_arbiter;

`ifdef HYPERRAM_ARB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif
   localparam int AW = 22;
   localparam int DW = 32;

   logic            userClock = 1'b0;
   logic            userResetN;
   logic [1:0]      reqValid;
   logic [1:0]      reqRead;
   logic [2*AW-1:0] reqAddress;
   logic [2*DW-1:0] reqWriteData;
   logic [1:0]      reqReady;
   logic [1:0]      rspValid;
   logic [DW-1:0]   rspData;
   logic            commandEnable;
   logic            cmdRead;
   logic [AW-1:0]   cmdAddress;
   logic [DW-1:0]   cmdWriteData;
   logic            ctrlBusy;
   logic            readDataValid;
   logic [DW-1:0]   readReg;
   logic            timeoutError;

   int checks = 0;
   int errors = 0;

   always #5 userClock = ~userClock;

   hyperram_cmd_arbiter #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .userClock     (userClock),
      .userResetN    (userResetN),
      .reqValid      (reqValid),
      .reqRead       (reqRead),
      .reqAddress    (reqAddress),
      .reqWriteData  (reqWriteData),
      .reqReady      (reqReady),
      .rspValid      (rspValid),
      .rspData       (rspData),
      .commandEnable (commandEnable),
      .cmdRead       (cmdRead),
      .cmdAddress    (cmdAddress),
      .cmdWriteData  (cmdWriteData),
      .ctrlBusy      (ctrlBusy),
      .readDataValid (readDataValid),
      .readReg       (readReg),
      .timeoutError  (timeoutError)
   );

   task automatic tick();
      @(posedge userClock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for any reqReady bit, then checks which one it is.
   task automatic wait_ready(input string tag, input logic [1:0] exp);
      int n;
      n = 0;
      while (reqReady == 2'b00 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, {62'd0, reqReady}, {62'd0, exp});
   endtask

   // reqReady must never offer both requesters at once.
   always @(negedge userClock) begin
      if (userResetN === 1'b1) begin
         checks++;
         assert (reqReady !== 2'b11) else begin
            errors++;
            $error("FAIL ready_onehot observed=0x%0h expected=not 0x3", reqReady);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      userResetN    = 1'b0;
      reqValid      = 2'b01;   // valid during reset must not raise ready
      reqRead       = 2'b00;
      reqAddress    = '0;
      reqWriteData  = '0;
      ctrlBusy      = 1'b0;
      readDataValid = 1'b0;
      readReg       = '0;
      tick();
      tick();

      // ---- reset state
      chk("rst_ready",    reqReady,      0);
      chk("rst_rspvalid", rspValid,      0);
      chk("rst_rspdata",  rspData,       0);
      chk("rst_cmden",    commandEnable, 0);
      chk("rst_cmdread",  cmdRead,       0);
      chk("rst_cmdaddr",  cmdAddress,    0);
      chk("rst_cmddata",  cmdWriteData,  0);
      chk("rst_timeout",  timeoutError,  0);
      userResetN = 1'b1;

      // ---- ready offered, valid withdrawn: no accept, pointer unchanged
      wait_ready("first_ready", 2'b01);
      reqValid = 2'b00;
      tick();
      chk("drop_cmden", commandEnable, 0);
      chk("drop_ready", reqReady, 0);
      reqValid = 2'b11;
      tick();
      chk("tie_after_drop", reqReady, 2'b01);

      // ---- single read, requester 0, address 0x000010
      reqValid = 2'b01;
      reqRead  = 2'b01;
      reqAddress[AW-1:0]    = 22'h000010;
      reqAddress[2*AW-1:AW] = 22'h0000AA;
      tick();                                   // accept edge
      reqValid = 2'b00;
      chk("rd0_cmden",   commandEnable, 1);
      chk("rd0_cmdread", cmdRead, 1);
      chk("rd0_cmdaddr", cmdAddress, 22'h000010);
      chk("rd0_ready_drop", reqReady, 0);
      tick();                                   // WAIT 1
      ctrlBusy = 1'b1;
      chk("rd0_cmden_1cyc", commandEnable, 0);
      chk("rd0_addr_hold", cmdAddress, 22'h000010);
      tick();
      chk("rd0_wait_norsp", rspValid, 0);
      readDataValid = 1'b1;
      readReg       = 32'hDEADBEEF;
      tick();
      readDataValid = 1'b0;
      readReg       = 32'h0;
      ctrlBusy      = 1'b0;
      chk("rd0_rspvalid", rspValid, 2'b01);
      chk("rd0_rspdata",  rspData, 32'hDEADBEEF);
      chk("rd0_no_ready_with_rsp", reqReady, 0);
      tick();
      chk("rd0_rsp_1cyc", rspValid, 0);

      // ---- stray read strobe in IDLE, then a read by requester 1
      readDataValid = 1'b1;
      readReg       = 32'hBADBAD00;
      tick();
      readDataValid = 1'b0;
      readReg       = 32'h0;
      chk("stray_norsp_a", rspValid, 0);
      tick();
      chk("stray_norsp_b", rspValid, 0);
      reqValid = 2'b10;
      reqRead  = 2'b10;
      reqAddress[2*AW-1:AW] = 22'h00002A;
      wait_ready("rd1_ready", 2'b10);
      tick();
      reqValid = 2'b00;
      chk("rd1_cmden",   commandEnable, 1);
      chk("rd1_cmdread", cmdRead, 1);
      chk("rd1_cmdaddr", cmdAddress, 22'h00002A);
      tick();
      ctrlBusy = 1'b1;
      tick();
      readDataValid = 1'b1;
      readReg       = 32'hCAFEF00D;
      tick();
      readDataValid = 1'b0;
      readReg       = 32'h0;
      ctrlBusy      = 1'b0;
      chk("rd1_rspvalid", rspValid, 2'b10);
      chk("rd1_rspdata",  rspData, 32'hCAFEF00D);

      // ---- write by requester 1, busy for 5 WAIT cycles, max address
      reqRead = 2'b00;
      reqAddress[2*AW-1:AW]   = 22'h3FFFFF;
      reqWriteData[2*DW-1:DW] = 32'h12345678;
      reqWriteData[DW-1:0]    = 32'hFFFFFFFF;
      reqValid = 2'b10;
      wait_ready("wr1_ready", 2'b10);
      tick();
      reqValid = 2'b00;
      chk("wr1_cmden",   commandEnable, 1);
      chk("wr1_cmdread", cmdRead, 0);
      chk("wr1_cmddata", cmdWriteData, 32'h12345678);
      chk("wr1_cmdaddr", cmdAddress, 22'h3FFFFF);
      tick();                                   // WAIT 1
      ctrlBusy = 1'b1;
      chk("wr1_cmden_1cyc", commandEnable, 0);
      tick();                                   // WAIT 2
      readDataValid = 1'b1;                     // must be ignored on a write
      readReg       = 32'h55555555;
      chk("wr1_norsp_2", rspValid, 0);
      tick();                                   // WAIT 3
      readDataValid = 1'b0;
      readReg       = 32'h0;
      chk("wr1_rdv_ignored", rspValid, 0);
      tick();                                   // WAIT 4
      chk("wr1_norsp_4", rspValid, 0);
      chk("wr1_data_hold", cmdWriteData, 32'h12345678);
      tick();                                   // WAIT 5
      chk("wr1_norsp_5", rspValid, 0);
      tick();                                   // WAIT 6: busy low
      ctrlBusy = 1'b0;
      chk("wr1_norsp_6", rspValid, 0);
      tick();
      chk("wr1_rspvalid", rspValid, 2'b10);
      chk("wr1_rspdata",  rspData, 0);

      // ---- both requesters valid continuously: order 0,1,0,1
      reqRead = 2'b00;
      reqAddress[AW-1:0]    = 22'h000100;
      reqAddress[2*AW-1:AW] = 22'h000200;
      reqValid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         logic [1:0]    exp_g;
         logic [AW-1:0] exp_a;
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_a = (k % 2 == 0) ? 22'h000100 : 22'h000200;
         wait_ready("rr_ready", exp_g);
         tick();
         chk("rr_cmdaddr", cmdAddress, exp_a);
         tick();
         ctrlBusy = 1'b1;
         tick();
         ctrlBusy = 1'b0;
         tick();
         chk("rr_rspvalid", rspValid, exp_g);
      end
      reqValid = 2'b00;

      // ---- reset in WAIT of a read by requester 0
      reqValid = 2'b01;
      reqRead  = 2'b01;
      reqAddress[AW-1:0] = 22'h000155;
      wait_ready("rst_rd_ready", 2'b01);
      tick();
      reqValid = 2'b00;
      chk("rst_rd_cmdaddr", cmdAddress, 22'h000155);
      tick();
      ctrlBusy = 1'b1;
      tick();
      #2;
      userResetN = 1'b0;
      #1;
      chk("arst_cmden",    commandEnable, 0);
      chk("arst_cmdaddr",  cmdAddress, 0);
      chk("arst_cmdread",  cmdRead, 0);
      chk("arst_cmddata",  cmdWriteData, 0);
      chk("arst_rspvalid", rspValid, 0);
      chk("arst_ready",    reqReady, 0);
      chk("arst_rspdata",  rspData, 0);
      chk("arst_timeout",  timeoutError, 0);
      ctrlBusy = 1'b0;
      tick();
      userResetN    = 1'b1;
      readDataValid = 1'b1;                     // late data for the abandoned read
      readReg       = 32'h77777777;
      tick();
      readDataValid = 1'b0;
      readReg       = 32'h0;
      chk("arst_late_norsp_a", rspValid, 0);
      tick();
      chk("arst_late_norsp_b", rspValid, 0);
      reqValid = 2'b11;
      reqRead  = 2'b11;
      reqAddress[AW-1:0] = 22'h000001;
      wait_ready("arst_tie_r0", 2'b01);
      tick();
      reqValid = 2'b00;
      chk("arst_rd_cmden",   commandEnable, 1);
      chk("arst_rd_cmdaddr", cmdAddress, 22'h000001);
      tick();
      ctrlBusy = 1'b1;
      tick();
      readDataValid = 1'b1;
      readReg       = 32'hA5A5A5A5;
      tick();
      readDataValid = 1'b0;
      readReg       = 32'h0;
      ctrlBusy      = 1'b0;
      chk("arst_rd_rspvalid", rspValid, 2'b01);
      chk("arst_rd_rspdata",  rspData, 32'hA5A5A5A5);
      chk("no_timeout_flag",  timeoutError, 0);

`ifdef HYPERRAM_ARB_TIMEOUT_EN
      // ---- silent controller: watchdog completes after 16 WAIT cycles
      reqValid = 2'b10;
      reqRead  = 2'b10;
      reqAddress[2*AW-1:AW] = 22'h000003;
      wait_ready("to_ready", 2'b10);
      tick();
      reqValid = 2'b00;
      tick();                                   // WAIT 1
      ctrlBusy = 1'b1;
      for (int i = 1; i < 16; i++) begin
         chk("to_norsp", rspValid, 0);
         chk("to_noflag", timeoutError, 0);
         tick();
      end
      chk("to_norsp_16", rspValid, 0);
      tick();
      chk("to_rspvalid", rspValid, 2'b10);
      chk("to_rspdata",  rspData, 0);
      chk("to_flag_set", timeoutError, 1);
      ctrlBusy = 1'b0;
      tick();
      chk("to_rsp_1cyc", rspValid, 0);
      chk("to_flag_sticky_a", timeoutError, 1);
      tick();
      chk("to_flag_sticky_b", timeoutError, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_hyperram_cmd_arbiter
`default_nettype wire
